// File: rtl/vga_stream_pkg.sv
// Shared layout of the 26-bit overlay pixel stream and screen/glyph constants.
package vga_stream_pkg;
  localparam int STR_W    = 26;
  localparam int ACTIVE   = 0;
  localparam int VS       = 1;
  localparam int HS       = 2;
  localparam int YC_LSB   = 3;
  localparam int XC_LSB   = 13;
  localparam int RGB_LSB  = 23;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int GLYPH    = 8;
endpackage

// File: rtl/hex_font_rom.sv
// Registered 8x8 font for the sixteen hex digits; row 0 is the top, bit 7 the leftmost pixel.
module hex_font_rom (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nibble,
  input  logic [2:0] row,
  output logic [7:0] row_bits
);

  function automatic logic [63:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 64'h3C666E7666663C00;
      4'h1: glyph = 64'h1838181818187E00;
      4'h2: glyph = 64'h3C66060C30607E00;
      4'h3: glyph = 64'h3C66061C06663C00;
      4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5: glyph = 64'h7E607C0606663C00;
      4'h6: glyph = 64'h3C607C6666663C00;
      4'h7: glyph = 64'h7E060C1830303000;
      4'h8: glyph = 64'h3C66663C66663C00;
      4'h9: glyph = 64'h3C66663E060C3800;
      4'hA: glyph = 64'h183C66667E666600;
      4'hB: glyph = 64'h7C66667C66667C00;
      4'hC: glyph = 64'h3C66606060663C00;
      4'hD: glyph = 64'h786C6666666C7800;
      4'hE: glyph = 64'h7E60607860607E00;
      default: glyph = 64'h7E60607860606000;
    endcase
  endfunction

  logic [63:0] w_glyph;
  assign w_glyph = glyph(nibble);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row_bits <= '0;
    else        row_bits <= w_glyph[6'd63 - {row, 3'b000} -: 8];
  end

endmodule

// File: rtl/vga_reg_hex.sv
// Hex register overlay: draws a double-buffered WIDTH-bit value as WIDTH/4 glyphs into the pixel stream.
// Optional per-digit change highlight: define VGA_REG_HEX_HIGHLIGHT_EN.
module vga_reg_hex
  import vga_stream_pkg::*;
#(
  parameter int         WIDTH       = 16,
  parameter int         ZOOM        = 3,
  parameter int         SEP         = 0,
  parameter logic [2:0] COLOR       = 3'b111,
  parameter logic [2:0] HL_COLOR    = 3'b100,
  parameter int         HOLD_FRAMES = 30
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic [25:0]      strRGB_i,
  input  logic [9:0]       x_pos,
  input  logic [9:0]       y_pos,
  input  logic [WIDTH-1:0] reg_i,
  input  logic             reg_load,
  output logic             reg_ack,
  output logic [25:0]      strRGB_o
);

  localparam int NDIG     = WIDTH / 4;
  localparam int GLYPH_PX = GLYPH << ZOOM;
  localparam int PITCH    = GLYPH_PX + SEP;

  // Handshake: reg_load is a one-cycle strobe with no back-pressure (a later load
  // overwrites pending); reg_ack pulses for one cycle right after pending becomes display.
  logic [WIDTH-1:0] r_pending, r_display;
  logic             r_pend_valid, r_ack;

  logic [9:0]  w_xc, w_yc, w_row_full;
  logic [10:0] w_dx, w_dy;
  logic        w_frame_start, w_swap, w_in_screen, w_row_ok;
  logic [WIDTH-1:0] w_disp_src;

  assign w_xc          = strRGB_i[XC_LSB +: 10];
  assign w_yc          = strRGB_i[YC_LSB +: 10];
  assign w_frame_start = (w_xc == 10'd0) && (w_yc == 10'd0);
  assign w_swap        = w_frame_start && r_pend_valid;
  assign w_dx          = {1'b0, w_xc} - {1'b0, x_pos};
  assign w_dy          = {1'b0, w_yc} - {1'b0, y_pos};
  assign w_row_full    = w_dy[9:0] >> ZOOM;
  assign w_row_ok      = !w_dy[10] && (w_row_full < 10'(GLYPH));
  assign w_in_screen   = (int'(w_xc) < SCREEN_W) && (int'(w_yc) < SCREEN_H);
  // The frame-start pixel already sees the incoming value so the frame is uniform.
  assign w_disp_src    = w_swap ? r_pending : r_display;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_display    <= '0;
      r_ack        <= 1'b0;
    end else begin
      r_ack <= w_swap;
      if (w_swap) begin
        r_display    <= r_pending;
        r_pend_valid <= 1'b0;
      end
      if (reg_load) begin
        r_pending    <= reg_i;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign reg_ack = r_ack;

`ifdef VGA_REG_HEX_HIGHLIGHT_EN
  localparam int CW = $clog2(HOLD_FRAMES + 1);
  logic [CW-1:0] r_hl_cnt [NDIG];

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NDIG; d++) r_hl_cnt[d] <= '0;
    end else if (w_frame_start) begin
      for (int d = 0; d < NDIG; d++) begin
        if (r_pend_valid && (r_pending[WIDTH-1-4*d -: 4] != r_display[WIDTH-1-4*d -: 4]))
          r_hl_cnt[d] <= CW'(HOLD_FRAMES);
        else if (r_hl_cnt[d] != '0)
          r_hl_cnt[d] <= r_hl_cnt[d] - CW'(1);
      end
    end
  end

  logic w_hl, r1_hl, r2_hl;
`endif

  logic       w_hit;
  logic [3:0] w_nib;
  logic [2:0] w_col;

  // Parallel per-digit window compares; the digit windows never overlap.
  always_comb begin
    w_hit = 1'b0;
    w_nib = '0;
    w_col = '0;
`ifdef VGA_REG_HEX_HIGHLIGHT_EN
    w_hl  = 1'b0;
`endif
    for (int d = 0; d < NDIG; d++) begin
      if (!w_dx[10] && (int'(w_dx[9:0]) >= d * PITCH) &&
          (int'(w_dx[9:0]) < d * PITCH + GLYPH_PX)) begin
        w_hit = w_row_ok && w_in_screen;
        w_nib = w_disp_src[WIDTH-1-4*d -: 4];
        w_col = 3'((w_dx[9:0] - 10'(d * PITCH)) >> ZOOM);
`ifdef VGA_REG_HEX_HIGHLIGHT_EN
        w_hl  = (r_hl_cnt[d] != '0);
`endif
      end
    end
  end

  logic [25:0] r1_str, r2_str;
  logic        r1_hit, r2_hit;
  logic [3:0]  r1_nib;
  logic [2:0]  r1_row, r1_col, r2_col;
  logic [7:0]  w_row_bits;
  logic [2:0]  w_color;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_str <= '0;
      r1_hit <= 1'b0;
      r1_nib <= '0;
      r1_row <= '0;
      r1_col <= '0;
      r2_str <= '0;
      r2_hit <= 1'b0;
      r2_col <= '0;
    end else begin
      r1_str <= strRGB_i;
      r1_hit <= w_hit;
      r1_nib <= w_nib;
      r1_row <= w_row_full[2:0];
      r1_col <= w_col;
      r2_str <= r1_str;
      r2_hit <= r1_hit;
      r2_col <= r1_col;
    end
  end

`ifdef VGA_REG_HEX_HIGHLIGHT_EN
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_hl <= 1'b0;
      r2_hl <= 1'b0;
    end else begin
      r1_hl <= w_hl;
      r2_hl <= r1_hl;
    end
  end
  assign w_color = r2_hl ? HL_COLOR : COLOR;
`else
  assign w_color = COLOR;
`endif

  hex_font_rom u_font (
    .clk      (px_clk),
    .rst_n    (rst_n),
    .nibble   (r1_nib),
    .row      (r1_row),
    .row_bits (w_row_bits)
  );

  always_comb begin
    strRGB_o = r2_str;
    if (r2_hit && r2_str[ACTIVE] && w_row_bits[3'd7 - r2_col])
      strRGB_o[RGB_LSB +: 3] = w_color;
  end

endmodule

// File: tb/tb_vga_reg_hex.sv
// Scoreboard bench for vga_reg_hex (default build, WIDTH=16, ZOOM=3, SEP=0, COLOR=3'b111).
module tb_vga_reg_hex;

  logic        px_clk;
  logic        rst_n;
  logic [25:0] strRGB_i;
  logic [9:0]  x_pos, y_pos;
  logic [15:0] reg_i;
  logic        reg_load;
  logic        reg_ack;
  logic [25:0] strRGB_o;

  logic [25:0] exp_q[$];
  logic [63:0] font_tb [16];
  logic [15:0] m_disp, m_pend;
  logic        m_pv;
  int          n_vec, n_err;

  // clock / reset
  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  vga_reg_hex #(.WIDTH(16)) dut (
    .px_clk   (px_clk),
    .rst_n    (rst_n),
    .strRGB_i (strRGB_i),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .reg_i    (reg_i),
    .reg_load (reg_load),
    .reg_ack  (reg_ack),
    .strRGB_o (strRGB_o)
  );

  task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: divide-based digit lookup over the bench's own glyph table.
  function automatic logic [25:0] model_px(input logic [25:0] s, input logic [15:0] disp);
    logic [25:0] r;
    logic [63:0] g;
    logic [7:0]  bits;
    logic [3:0]  nib;
    int x, y, dx, dy, d, off;
    r  = s;
    x  = int'(s[22:13]);
    y  = int'(s[12:3]);
    dx = x - int'(x_pos);
    dy = y - int'(y_pos);
    if (s[0] && x < 800 && y < 600 && dx >= 0 && dy >= 0 && dy < 64) begin
      d   = dx / 64;
      off = dx % 64;
      if (d < 4) begin
        nib  = 4'(disp >> (4 * (3 - d)));
        g    = font_tb[nib];
        bits = g[63 - 8 * (dy / 8) -: 8];
        if (bits[7 - off / 8]) r[25:23] = 3'b111;
      end
    end
    return r;
  endfunction

  // driver: one pixel per cycle; output lags input by two edges
  task automatic step(input int x, input int y, input logic act, input logic ld, input logic [15:0] val);
    logic [25:0] s, e;
    logic        fs, exp_ack;
    s = {3'($urandom_range(0, 7)), 10'(x), 10'(y), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), act};
    strRGB_i = s;
    reg_load = ld;
    reg_i    = val;
    fs       = (x == 0) && (y == 0);
    exp_ack  = fs && m_pv;
    if (fs && m_pv) begin
      m_disp = m_pend;
      m_pv   = 1'b0;
    end
    exp_q.push_back(model_px(s, m_disp));
    if (ld) begin
      m_pend = val;
      m_pv   = 1'b1;
    end
    @(posedge px_clk); #1;
    check_eq("ack", {25'd0, reg_ack}, {25'd0, exp_ack});
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_eq("pix", strRGB_o, e);
    end
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) step(x, y, 1'b1, 1'b0, 16'h0);
  endtask

  task automatic scan_box();
    scan(50, 95, 360);
    scan(62, 95, 360);
    scan(74, 95, 360);
  endtask

  task automatic scan_box_lower();
    scan(98, 95, 360);
    scan(113, 95, 360);
    scan(114, 95, 360);
    scan(49, 95, 120);
  endtask

  initial begin
    font_tb[0]  = 64'h3C666E7666663C00; font_tb[1]  = 64'h1838181818187E00;
    font_tb[2]  = 64'h3C66060C30607E00; font_tb[3]  = 64'h3C66061C06663C00;
    font_tb[4]  = 64'h0C1C3C6C7E0C0C00; font_tb[5]  = 64'h7E607C0606663C00;
    font_tb[6]  = 64'h3C607C6666663C00; font_tb[7]  = 64'h7E060C1830303000;
    font_tb[8]  = 64'h3C66663C66663C00; font_tb[9]  = 64'h3C66663E060C3800;
    font_tb[10] = 64'h183C66667E666600; font_tb[11] = 64'h7C66667C66667C00;
    font_tb[12] = 64'h3C66606060663C00; font_tb[13] = 64'h786C6666666C7800;
    font_tb[14] = 64'h7E60607860607E00; font_tb[15] = 64'h7E60607860606000;
    n_vec = 0; n_err = 0;
    m_disp = '0; m_pend = '0; m_pv = 1'b0;
    strRGB_i = '0; reg_i = '0; reg_load = 1'b0;
    x_pos = 10'd100; y_pos = 10'd50;
    rst_n = 1'b0;
    repeat (3) @(posedge px_clk);
    #1;
    check_eq("rst_str", strRGB_o, 26'd0);
    check_eq("rst_ack", {25'd0, reg_ack}, 26'd0);
    rst_n = 1'b1;

    // load before frame start, swap with ack, draw "1A2F"
    step(500, 500, 1'b1, 1'b1, 16'h1A2F);
    step(0, 0, 1'b1, 1'b0, 16'h0);
    scan_box();
    // mid-frame load: rest of this frame still shows 1A2F
    step(400, 80, 1'b1, 1'b1, 16'h1234);
    scan_box_lower();
    step(0, 0, 1'b1, 1'b0, 16'h0);
    scan_box();
    scan_box_lower();

    // load on the frame-start cycle keeps pend_valid set
    step(400, 200, 1'b1, 1'b1, 16'hABCD);
    step(0, 0, 1'b1, 1'b1, 16'h5678);
    scan_box();
    step(0, 0, 1'b0, 1'b0, 16'h0);
    scan_box();
    // frame start with nothing pending: no ack, value retained
    step(0, 0, 1'b1, 1'b0, 16'h0);
    scan(62, 95, 360);

    // reset mid-frame while BEEF is displayed
    step(400, 300, 1'b1, 1'b1, 16'hBEEF);
    step(0, 0, 1'b1, 1'b0, 16'h0);
    scan(50, 95, 200);
    step(108, 50, 1'b1, 1'b0, 16'h0);
    step(108, 50, 1'b1, 1'b0, 16'h0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_str", strRGB_o, 26'd0);
    check_eq("rst_mid_ack", {25'd0, reg_ack}, 26'd0);
    exp_q.delete();
    m_disp = '0; m_pend = '0; m_pv = 1'b0;
    @(posedge px_clk); #1;
    rst_n = 1'b1;
    step(0, 0, 1'b1, 1'b0, 16'h0);
    scan_box();

    // right-edge placement must not wrap into XC 0..20
    x_pos = 10'd780;
    step(500, 500, 1'b1, 1'b1, 16'hFFFF);
    step(0, 0, 1'b1, 1'b0, 16'h0);
    scan(50, 1, 20);
    scan(50, 770, 799);
    scan(62, 0, 20);
    scan(62, 770, 799);

    step(1000, 1000, 1'b0, 1'b0, 16'h0);
    step(1000, 1000, 1'b0, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
